load_store_unit: RTL
====================

// Module: load_store_unit
// PURPOSE
//  Initiator side of the data-memory port: accepts one load/store request at a time from the
//  datapath over a valid/ready handshake. Drives the data memory's address, write-data,
//  write-enable and read-enable pins, and returns load data or store completion over a
//  valid/ready response channel.
//  Sits between the control/ALU stage and the data memory. The memory reads combinationally
//  and writes on the clock edge.
// PARAMETERS
//  ADDR_W     16  request/memory address width
//  DATA_W     16  data word width
//  MEM_DEPTH  8   number of implemented memory words; used only by the address check
// PORTS
//  clk              in   1       system clock, all state on rising edge
//  reset            in   1       asynchronous, active-low reset (0 = reset)
//  req_valid        in   1       request present
//  req_ready        out  1       unit can accept a request
//  req_write        in   1       1 = store, 0 = load
//  req_addr         in   ADDR_W  word address
//  req_wdata        in   DATA_W  store data
//  rsp_valid        out  1       response present
//  rsp_ready        in   1       datapath takes the response
//  rsp_rdata        out  DATA_W  load data; 0 for stores and errors
//  rsp_err          out  1       address-check failure
//  mem_access_addr  out  ADDR_W  to memory address pin
//  mem_write_data   out  DATA_W  to memory write-data pin
//  mem_write_en     out  1       to memory write enable
//  mem_read         out  1       to memory read enable
//  mem_read_data    in   DATA_W  from memory, combinational
//  busy             out  1       state != IDLE
//  txn_count        out  16      completed response handshakes
// BEHAVIOUR
//  - Reset value of every output is 0, except req_ready = 1. Reset clears all registers and
//    sets state = IDLE. It acts immediately, independent of clk.
//  - FSM states:
//    - IDLE: req_ready = 1.
//      - req_valid & req_ready latches write/addr/wdata into internal registers and moves to
//        ISSUE.
//    - ISSUE (exactly 1 cycle): req_ready = 0.
//      - mem_access_addr = latched addr; mem_write_data = latched wdata.
//      - mem_write_en = latched write; mem_read = ~latched write.
//      - At the closing edge: rsp_rdata <= (load ? mem_read_data : 0), rsp_err <= 0, state
//        moves to RESP.
//    - RESP: rsp_valid = 1, with rsp_rdata and rsp_err held stable.
//      - rsp_valid & rsp_ready: txn_count increments, state moves to IDLE.
//      - Without rsp_ready, RESP holds indefinitely.
//  - Latency: accept at edge E0; the memory write commits at E1; rsp_valid is high from E1.
//    Maximum throughput is one transaction per 3 cycles, with no bypass from RESP to IDLE.
//  - Outside ISSUE, mem_write_en = mem_read = 0. mem_access_addr and mem_write_data keep their
//    last driven values; they are registered outputs and never glitch.
//  - Request inputs are ignored outside IDLE. A req_valid held high during ISSUE or RESP is
//    accepted only on the first IDLE cycle.
//  - txn_count is 16-bit and wraps 0xFFFF -> 0x0000.
//  - Reset during ISSUE: mem_write_en drops to 0 asynchronously, so no write occurs at the
//    following edge.
//  - Reset during RESP: the response is discarded and txn_count is cleared.
// CONFIGURATION
//  Macro LSU_ADDR_CHECK_EN:
//  - Defined: at accept, if req_addr >= MEM_DEPTH, the unit skips ISSUE and goes directly to
//    RESP at E0.
//    - No memory enable is asserted.
//    - rsp_err = 1, rsp_rdata = 0.
//    - The response still counts in txn_count.
//  - Undefined: rsp_err is tied to 0. All addresses are forwarded unchanged, and the memory
//    aliases on its low address bits.
// STRUCTURE
//  - Package lsu_pkg: state enum {IDLE, ISSUE, RESP}, and default constants for ADDR_W, DATA_W
//    and MEM_DEPTH.
//  - One sub-module, lsu_addr_check: combinational compare of addr >= MEM_DEPTH. It is
//    instantiated only under LSU_ADDR_CHECK_EN.
//  - FSM, latches and counter live in load_store_unit itself.
// TESTING
//  1. Reset, then store addr=3 wdata=0xBEEF.
//     -> mem_write_en = 1 for exactly 1 cycle with mem_access_addr = 3.
//     -> rsp_valid at E1, rsp_rdata = 0, txn_count = 1.
//  2. Preload memory word 5 = 0x1234, then load addr=5.
//     -> mem_read = 1 for 1 cycle; rsp_rdata = 0x1234 at E1.
//     -> Hold rsp_ready = 0 for 4 cycles: rsp_valid and rsp_rdata stay stable, req_ready = 0.
//  3. Back-to-back store 0xA5A5 to addr 2, then load addr 2, with req_valid held high.
//     -> Second request is accepted in the first IDLE cycle after response 1.
//     -> Load returns 0xA5A5.
//  4. Assert reset mid-ISSUE of a store of 0x00FF to addr 1 (memory word 1 preloaded with
//     0x0000).
//     -> Memory word 1 remains 0x0000.
//     -> All outputs return to reset values, req_ready = 1.
//  5. With LSU_ADDR_CHECK_EN, load addr=8 and then store addr=0x0010.
//     -> No mem enables are asserted; rsp_err = 1 at E0; rsp_rdata = 0.
//     -> Without the macro, a load of addr=8 returns memory word 0.
//  6. Force txn_count to 0xFFFF and complete one transaction -> txn_count = 0x0000.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and default sizing for the load/store unit.
package lsu_pkg;

  localparam int unsigned LSU_ADDR_W    = 16;
  localparam int unsigned LSU_DATA_W    = 16;
  localparam int unsigned LSU_MEM_DEPTH = 8;
  localparam int unsigned LSU_TXN_W     = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } lsu_state_e;

endpackage

// File: rtl/lsu_if.sv
// Request/response channel plus data-memory pins of the load/store unit.
interface lsu_if
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W = LSU_ADDR_W,
  parameter int unsigned DATA_W = LSU_DATA_W
) ();

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  logic [ADDR_W-1:0] mem_access_addr;
  logic [DATA_W-1:0] mem_write_data;
  logic              mem_write_en;
  logic              mem_read;
  logic [DATA_W-1:0] mem_read_data;

  // The unit itself
  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, rsp_ready, mem_read_data,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output mem_access_addr, mem_write_data, mem_write_en, mem_read
  );

  // Datapath plus memory, seen from outside the unit
  modport master (
    output req_valid, req_write, req_addr, req_wdata, rsp_ready, mem_read_data,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  mem_access_addr, mem_write_data, mem_write_en, mem_read
  );

endinterface

// File: rtl/lsu_addr_check.sv
// Flags word addresses beyond the implemented memory depth.
module lsu_addr_check
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W    = LSU_ADDR_W,
  parameter int unsigned MEM_DEPTH = LSU_MEM_DEPTH
) (
  input  logic [ADDR_W-1:0] i_addr,
  output logic              o_err
);

  assign o_err = (32'(i_addr) >= MEM_DEPTH);

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store initiator for the data memory.
// Optional macro LSU_ADDR_CHECK_EN: out-of-range addresses answer with rsp_err, no memory access.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W    = LSU_ADDR_W,
  parameter int unsigned DATA_W    = LSU_DATA_W,
  parameter int unsigned MEM_DEPTH = LSU_MEM_DEPTH
) (
  input  logic                 clk,
  input  logic                 reset,
  lsu_if.slave                 bus,
  output logic                 busy,
  output logic [LSU_TXN_W-1:0] txn_count
);

  // state | meaning
  // IDLE  | ready for a request
  // ISSUE | memory pins driven for one cycle, load data captured at its closing edge
  // RESP  | response held until the datapath takes it

  lsu_state_e            r_state;
  lsu_state_e            w_state_nxt;
  logic                  r_write;
  logic [ADDR_W-1:0]     r_mem_addr;
  logic [DATA_W-1:0]     r_mem_wdata;
  logic [DATA_W-1:0]     r_rsp_rdata;
  logic                  r_rsp_err;
  logic [LSU_TXN_W-1:0]  r_txn_count;
  logic                  w_accept;
  logic                  w_rsp_done;
  logic                  w_addr_err;

`ifdef LSU_ADDR_CHECK_EN
  lsu_addr_check #(
    .ADDR_W    (ADDR_W),
    .MEM_DEPTH (MEM_DEPTH)
  ) u_addr_check (
    .i_addr (bus.req_addr),
    .o_err  (w_addr_err)
  );
`else
  assign w_addr_err = 1'b0;
`endif

  assign w_accept   = (r_state == IDLE) && bus.req_valid;
  assign w_rsp_done = (r_state == RESP) && bus.rsp_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    bus.req_ready    = 1'b0;
    bus.rsp_valid    = 1'b0;
    bus.mem_write_en = 1'b0;
    bus.mem_read     = 1'b0;
    busy             = 1'b1;
    case (r_state)
      IDLE: begin
        bus.req_ready = 1'b1;
        busy          = 1'b0;
        if (bus.req_valid) begin
          w_state_nxt = w_addr_err ? RESP : ISSUE;
        end
      end
      ISSUE: begin
        // Enables decode straight from the state register so reset kills them at once
        bus.mem_write_en = r_write;
        bus.mem_read     = ~r_write;
        w_state_nxt      = RESP;
      end
      RESP: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_write     <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else if (w_accept) begin
      r_write <= bus.req_write;
      if (w_addr_err) begin
        r_rsp_rdata <= '0;
        r_rsp_err   <= 1'b1;
      end else begin
        r_mem_addr  <= bus.req_addr;
        r_mem_wdata <= bus.req_wdata;
      end
    end else if (r_state == ISSUE) begin
      r_rsp_rdata <= r_write ? '0 : bus.mem_read_data;
      r_rsp_err   <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_txn_count <= '0;
    end else if (w_rsp_done) begin
      r_txn_count <= r_txn_count + 1'b1;
    end
  end

  assign bus.mem_access_addr = r_mem_addr;
  assign bus.mem_write_data  = r_mem_wdata;
  assign bus.rsp_rdata       = r_rsp_rdata;
  assign bus.rsp_err         = r_rsp_err;
  assign txn_count           = r_txn_count;

endmodule
